// File: rtl/ton_pow_nonce_scanner.sv
// ton_pow_nonce_scanner: drives a 3-block SHA-256 core with a job template
// plus a 64-bit nonce, compares each digest against a target, and counts
// tried nonces and hits.
// Build option: define NONCE_SCANNER_STOP_ON_HIT_EN to end a scan at the
// first hit. When it is undefined, the scan runs the full count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for i_go; job inputs are latched here
// S_LOAD  | insert the current nonce into the message register
// S_ISSUE | single-cycle start pulse to the core
// S_WAIT  | core busy; message held stable until i_hash_ready
// S_CHECK | compare the digest, update counters, advance the nonce
// S_DONE  | scan finished; o_done pulses in the following cycle
module ton_pow_nonce_scanner #(
   parameter int NONCE_OFFSET = 64,
   parameter int CNT_W        = 32
) (
   input  logic             i_clk,
   input  logic             i_n_reset,
   input  logic [7:0]       i_job_data [123],
   input  logic [255:0]     i_target,
   input  logic [63:0]      i_nonce_start,
   input  logic [CNT_W-1:0] i_nonce_count,
   input  logic             i_go,
   input  logic             i_abort,
   output logic             o_busy,
   output logic             o_done,
   output logic [7:0]       o_hash_data [123],
   output logic             o_hash_start,
   input  logic [7:0]       i_hash_data [32],
   input  logic             i_hash_ready,
   output logic             o_hit,
   output logic [63:0]      o_hit_nonce,
   output logic [255:0]     o_hit_hash,
   output logic [CNT_W-1:0] o_tried,
   output logic [CNT_W-1:0] o_hit_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CHECK, S_DONE
   } state_t;

   state_t           r_state, w_next;
   logic [7:0]       r_msg [123];
   logic [255:0]     r_target;
   logic [255:0]     r_digest;
   logic [63:0]      r_nonce;
   logic [CNT_W-1:0] r_remain;
   logic             r_abort_pend;
   logic             r_done;
   logic             r_hit;
   logic [63:0]      r_hit_nonce;
   logic [255:0]     r_hit_hash;
   logic [CNT_W-1:0] r_tried;
   logic [CNT_W-1:0] r_hit_count;

   logic [255:0]     w_digest;
   logic             w_hit;
   logic             w_abort;
   logic             w_last;
   logic             w_stop;

   assign w_hit   = (r_digest < r_target);
   assign w_abort = r_abort_pend | i_abort;
   assign w_last  = (r_remain == CNT_W'(1));

`ifdef NONCE_SCANNER_STOP_ON_HIT_EN
   assign w_stop = w_hit;
`else
   assign w_stop = 1'b0;
`endif

   // Flatten the digest bytes into a big-endian word (byte 0 is the MSB).
   always_comb begin
      w_digest = '0;
      for (int i = 0; i < 32; i++) begin
         w_digest[255-8*i -: 8] = i_hash_data[i];
      end
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_go) w_next = (i_nonce_count == '0) ? S_DONE : S_LOAD;
         // An abort seen in LOAD ends the scan before any start is issued, so
         // ISSUE never has an abort pending when it pulses o_hash_start.
         S_LOAD:  w_next = w_abort ? S_DONE : S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (i_hash_ready) w_next = w_abort ? S_DONE : S_CHECK;
         S_CHECK: w_next = (w_last || w_abort || w_stop) ? S_DONE : S_LOAD;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   // Job latching, nonce insertion, digest capture and scan counters.
   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_msg        <= '{default: 8'h00};
         r_target     <= '0;
         r_digest     <= '0;
         r_nonce      <= '0;
         r_remain     <= '0;
         r_abort_pend <= 1'b0;
         r_done       <= 1'b0;
         r_hit        <= 1'b0;
         r_hit_nonce  <= '0;
         r_hit_hash   <= '0;
         r_tried      <= '0;
         r_hit_count  <= '0;
      end else begin
         r_done <= (r_state == S_DONE);
         if (r_state == S_IDLE) r_abort_pend <= 1'b0;
         else if (i_abort)      r_abort_pend <= 1'b1;
         case (r_state)
            S_IDLE: if (i_go) begin
               // The template goes straight into the message register; LOAD
               // then only overwrites the eight nonce bytes.
               r_msg       <= i_job_data;
               r_target    <= i_target;
               r_nonce     <= i_nonce_start;
               r_remain    <= i_nonce_count;
               r_hit       <= 1'b0;
               r_tried     <= '0;
               r_hit_count <= '0;
            end
            S_LOAD: begin
               for (int k = 0; k < 8; k++) begin
                  r_msg[NONCE_OFFSET+k] <= r_nonce[63-8*k -: 8];
               end
            end
            S_WAIT: if (i_hash_ready) r_digest <= w_digest;
            S_CHECK: begin
               if (r_tried != '1) r_tried <= r_tried + CNT_W'(1);
               if (w_hit) begin
                  if (r_hit_count != '1) r_hit_count <= r_hit_count + CNT_W'(1);
                  if (!r_hit) begin
                     r_hit       <= 1'b1;
                     r_hit_nonce <= r_nonce;
                     r_hit_hash  <= r_digest;
                  end
               end
               r_nonce  <= r_nonce + 64'd1;
               r_remain <= r_remain - CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = r_done;
   assign o_hash_data  = r_msg;
   assign o_hash_start = (r_state == S_ISSUE);
   assign o_hit        = r_hit;
   assign o_hit_nonce  = r_hit_nonce;
   assign o_hit_hash   = r_hit_hash;
   assign o_tried      = r_tried;
   assign o_hit_count  = r_hit_count;

endmodule

// File: tb/tb_ton_pow_nonce_scanner.sv
// Directed bench for ton_pow_nonce_scanner with a behavioural SHA core stand-in
// that returns a digest derived from the nonce it was sent.
module tb_ton_pow_nonce_scanner;

   logic          clk = 1'b0;
   logic          n_reset;
   logic [7:0]    job [123];
   logic [255:0]  target;
   logic [63:0]   nonce_start;
   logic [31:0]   nonce_count;
   logic          go, abort;
   logic          busy, done;
   logic [7:0]    hash_out [123];
   logic          hash_start;
   logic [7:0]    hash_in [32];
   logic          hash_ready;
   logic          hit;
   logic [63:0]   hit_nonce;
   logic [255:0]  hit_hash;
   logic [31:0]   tried, hit_count;

   int            total = 0;
   int            passes = 0;
   int            n_start = 0;
   logic [63:0]   nq [$];
   logic [63:0]   hit_a = 64'hDEAD, hit_b = 64'hDEAD;
   logic [63:0]   core_n, core_chk;
   logic [255:0]  core_d;
   int            cyc;
   int            extra;

   always #5 clk = ~clk;

   ton_pow_nonce_scanner dut (
      .i_clk(clk), .i_n_reset(n_reset), .i_job_data(job), .i_target(target),
      .i_nonce_start(nonce_start), .i_nonce_count(nonce_count), .i_go(go),
      .i_abort(abort), .o_busy(busy), .o_done(done), .o_hash_data(hash_out),
      .o_hash_start(hash_start), .i_hash_data(hash_in), .i_hash_ready(hash_ready),
      .o_hit(hit), .o_hit_nonce(hit_nonce), .o_hit_hash(hit_hash),
      .o_tried(tried), .o_hit_count(hit_count)
   );

   function automatic logic [255:0] dig(input logic [63:0] n);
      if (n == hit_a || n == hit_b) return {64'h0, n, 128'h0};
      return {8'hFF, 184'h0, n};
   endfunction

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scan from a negedge; optionally abort / re-pulse go at given cycle numbers.
   task automatic run(input logic [63:0] st, input logic [31:0] cnt, input logic [255:0] tgt,
                      input int abort_at, input int poke_at, output int c);
      nonce_start = st; nonce_count = cnt; target = tgt;
      nq.delete(); n_start = 0;
      go = 1'b1; abort = (abort_at == 0);
      c = 0;
      do begin
         @(negedge clk); c++;
         go    = (c == poke_at);
         abort = (c == abort_at);
         if (c == poke_at) nonce_count = 32'd0;
      end while (!done && c < 400);
      go = 1'b0; abort = 1'b0;
      check("timeout", c < 400, 1);
      check("busy_at_done", busy, 0);
   endtask

   task automatic quiet_after;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) extra++;
         if (hash_start) extra++;
      end
      check("no_extra_done_or_start", extra, 0);
   endtask

   // Core stand-in: 3-cycle latency, checks the message is held meanwhile.
   initial begin
      for (int i = 0; i < 32; i++) hash_in[i] = 8'h00;
      hash_ready = 1'b0;
      forever begin
         @(negedge clk);
         hash_ready = 1'b0;
         if (hash_start) begin
            for (int k = 0; k < 8; k++) core_n[63-8*k -: 8] = hash_out[64+k];
            nq.push_back(core_n);
            n_start++;
            check("tmpl_byte63", hash_out[63], job[63]);
            check("tmpl_byte72", hash_out[72], job[72]);
            repeat (2) @(negedge clk);
            for (int k = 0; k < 8; k++) core_chk[63-8*k -: 8] = hash_out[64+k];
            check("msg_held", core_chk, core_n);
            core_d = dig(core_n);
            for (int i = 0; i < 32; i++) hash_in[i] = core_d[255-8*i -: 8];
            hash_ready = 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 123; i++) job[i] = 8'(i) ^ 8'h5A;
      target = '0; nonce_start = '0; nonce_count = '0; go = 1'b0; abort = 1'b0;
      n_reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_start", hash_start, 0);
      check("rst_hit", hit, 0);
      check("rst_tried", tried, 0);
      check("rst_hit_count", hit_count, 0);
      check("rst_hit_hash", hit_hash, 0);
      check("rst_msg0", hash_out[0], 0);
      check("rst_msg70", hash_out[70], 0);
      n_reset = 1'b1;
      @(negedge clk);

      // target 0, start 100, count 4; abort together with go must be ignored
      run(64'd100, 32'd4, 256'h0, 0, -1, cyc);
      check("t1_cycles", cyc, 22);
      check("t1_starts", n_start, 4);
      for (int i = 0; i < 4; i++) check("t1_nonce", (nq.size() > i) ? nq[i] : 64'hX, 64'(100 + i));
      check("t1_tried", tried, 4);
      check("t1_hit", hit, 0);
      check("t1_hit_count", hit_count, 0);
      quiet_after();

      // target all-ones, start 5, count 1
      run(64'd5, 32'd1, {256{1'b1}}, -1, -1, cyc);
      check("t2_cycles", cyc, 7);
      check("t2_hit", hit, 1);
      check("t2_hit_nonce", hit_nonce, 64'd5);
      check("t2_hit_hash", hit_hash, {8'hFF, 184'h0, 64'd5});
      check("t2_tried", tried, 1);

      // nonce wrap; go pulsed while busy must be ignored
      run(64'hFFFF_FFFF_FFFF_FFFE, 32'd3, 256'h0, -1, 6, cyc);
      check("t3_cycles", cyc, 17);
      check("t3_starts", n_start, 3);
      check("t3_n0", (nq.size() > 0) ? nq[0] : 64'hX, 64'hFFFF_FFFF_FFFF_FFFE);
      check("t3_n1", (nq.size() > 1) ? nq[1] : 64'hX, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t3_n2", (nq.size() > 2) ? nq[2] : 64'hX, 64'h0);
      check("t3_tried", tried, 3);
      quiet_after();

      // count 0: done two cycles after go, no start
      run(64'd1, 32'd0, 256'h0, -1, -1, cyc);
      check("t4_cycles", cyc, 2);
      check("t4_starts", n_start, 0);
      check("t4_tried", tried, 0);

      // abort during WAIT of the second nonce
      run(64'd0, 32'd10, 256'h0, 8, -1, cyc);
      check("t5_cycles", cyc, 11);
      check("t5_starts", n_start, 2);
      check("t5_tried", tried, 1);
      quiet_after();

      // strict compare: nonce 6 below target, nonce 7 equal to target
      run(64'd6, 32'd2, {8'hFF, 184'h0, 64'd7}, -1, -1, cyc);
      check("t6_hit", hit, 1);
      check("t6_hit_nonce", hit_nonce, 64'd6);
      check("t6_hit_count", hit_count, 1);
`ifdef NONCE_SCANNER_STOP_ON_HIT_EN
      check("t6_tried", tried, 1);
`else
      check("t6_tried", tried, 2);
`endif

      // nonces 12 and 14 hit in a scan of 10..15
      hit_a = 64'd12; hit_b = 64'd14;
      run(64'd10, 32'd6, {64'h1, 192'h0}, -1, -1, cyc);
      check("t7_hit", hit, 1);
      check("t7_hit_nonce", hit_nonce, 64'd12);
      check("t7_hit_hash", hit_hash, {64'h0, 64'd12, 128'h0});
`ifdef NONCE_SCANNER_STOP_ON_HIT_EN
      check("t7_tried", tried, 3);
      check("t7_hit_count", hit_count, 1);
`else
      check("t7_tried", tried, 6);
      check("t7_hit_count", hit_count, 2);
`endif
      quiet_after();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
